// File: rtl/id_stage_ctrl.sv
// Decode-stage controller for a 5-stage RV32I pipeline: owns the IF/ID and ID/EX
// registers, decodes EX control bits and sequences stalls, flushes and freezes.
module id_stage_ctrl #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_valid,
   input  logic [31:0]      if_instr,
   input  logic [31:0]      if_pc,
   input  logic             ex_flush,
   input  logic             mem_stall,
   output logic             pc_hold,
   output logic [31:0]      id_instr,
   output logic             imm_sel,
   output logic [4:0]       rs1_addr,
   output logic [4:0]       rs2_addr,
   output logic             ex_valid,
   output logic [31:0]      ex_pc,
   output logic [4:0]       ex_rd,
   output logic             ex_alu_src,
   output logic             ex_reg_write,
   output logic             ex_mem_read,
   output logic             ex_mem_write,
   output logic             ex_branch,
   output logic             ex_jump,
   output logic             ex_illegal,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        alu_src;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        illegal;
   } idex_t;

   logic             id_valid_q, id_valid_d;
   logic [31:0]      id_instr_q, id_instr_d;
   logic [31:0]      id_pc_q, id_pc_d;
   idex_t            ex_q, ex_d;
   idex_t            dec_ex;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   logic dec_alu_src, dec_reg_write, dec_mem_read, dec_mem_write;
   logic dec_branch, dec_jump, dec_illegal, dec_imm_sel;
   logic rs1_used, rs2_used;
   logic load_use;

   // Opcode decode of the instruction currently held in IF/ID.
   always_comb begin
      dec_alu_src   = 1'b0;
      dec_reg_write = 1'b0;
      dec_mem_read  = 1'b0;
      dec_mem_write = 1'b0;
      dec_branch    = 1'b0;
      dec_jump      = 1'b0;
      dec_illegal   = 1'b0;
      dec_imm_sel   = 1'b0;
      rs1_used      = 1'b1;
      rs2_used      = 1'b0;
      case (id_instr_q[6:0])
         OPC_LOAD: begin
            dec_alu_src   = 1'b1;
            dec_reg_write = 1'b1;
            dec_mem_read  = 1'b1;
            dec_imm_sel   = 1'b1;
         end
         OPC_OP_IMM: begin
            dec_alu_src   = 1'b1;
            dec_reg_write = 1'b1;
            dec_imm_sel   = 1'b1;
         end
         OPC_JALR: begin
            dec_alu_src   = 1'b1;
            dec_reg_write = 1'b1;
            dec_jump      = 1'b1;
            dec_imm_sel   = 1'b1;
         end
         OPC_STORE: begin
            dec_alu_src   = 1'b1;
            dec_mem_write = 1'b1;
            dec_imm_sel   = 1'b1;
            rs2_used      = 1'b1;
         end
         OPC_BRANCH: begin
            dec_branch    = 1'b1;
            dec_imm_sel   = 1'b1;
            rs2_used      = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: begin
            dec_alu_src   = 1'b1;
            dec_reg_write = 1'b1;
            dec_imm_sel   = 1'b1;
            rs1_used      = 1'b0;
         end
         OPC_JAL: begin
            dec_reg_write = 1'b1;
            dec_jump      = 1'b1;
            dec_imm_sel   = 1'b1;
            rs1_used      = 1'b0;
         end
         OPC_OP: begin
            dec_reg_write = 1'b1;
            rs2_used      = 1'b1;
         end
         default: begin
            dec_illegal   = 1'b1;
         end
      endcase
   end

   // Candidate ID/EX contents; an invalid IF/ID slot carries no controls.
   always_comb begin
      dec_ex       = '0;
      dec_ex.valid = id_valid_q;
      dec_ex.pc    = id_pc_q;
      if (id_valid_q) begin
         dec_ex.rd        = dec_reg_write ? id_instr_q[11:7] : 5'd0;
         dec_ex.alu_src   = dec_alu_src;
         dec_ex.reg_write = dec_reg_write;
         dec_ex.mem_read  = dec_mem_read;
         dec_ex.mem_write = dec_mem_write;
         dec_ex.branch    = dec_branch;
         dec_ex.jump      = dec_jump;
         dec_ex.illegal   = dec_illegal;
      end
   end

   assign rs1_addr = id_instr_q[19:15];
   assign rs2_addr = id_instr_q[24:20];

   // ex_rd is zero for non-writing instructions, so x0 can never match here.
   assign load_use = id_valid_q & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                     ((rs1_used & (ex_q.rd == rs1_addr)) |
                      (rs2_used & (ex_q.rd == rs2_addr)));

   // Fetch handshake: if_valid/if_instr/if_pc are consumed at a rising edge only
   // while pc_hold is low; with pc_hold high fetch re-presents the same values.
   assign pc_hold = mem_stall | (~ex_flush & load_use);

   always_comb begin
      id_valid_d    = id_valid_q;
      id_instr_d    = id_instr_q;
      id_pc_d       = id_pc_q;
      ex_d          = ex_q;
      stall_count_d = stall_count_q;
      if (mem_stall) begin
         // Whole front end frozen; a pending flush is re-presented upstream.
      end else if (ex_flush) begin
         id_valid_d = 1'b0;
         id_instr_d = NOP_INSTR;
         id_pc_d    = 32'd0;
         ex_d       = '0;
      end else if (load_use) begin
         ex_d = '0;
         if (stall_count_q != {CNT_W{1'b1}}) begin
            stall_count_d = stall_count_q + CNT_W'(1);
         end
      end else begin
         id_valid_d = if_valid;
         id_instr_d = if_instr;
         id_pc_d    = if_pc;
         ex_d       = dec_ex;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_valid_q    <= 1'b0;
         id_instr_q    <= NOP_INSTR;
         id_pc_q       <= 32'd0;
         ex_q          <= '0;
         stall_count_q <= '0;
      end else begin
         id_valid_q    <= id_valid_d;
         id_instr_q    <= id_instr_d;
         id_pc_q       <= id_pc_d;
         ex_q          <= ex_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign id_instr     = id_instr_q;
   assign imm_sel      = id_valid_q & dec_imm_sel;
   assign ex_valid     = ex_q.valid;
   assign ex_pc        = ex_q.pc;
   assign ex_rd        = ex_q.rd;
   assign ex_alu_src   = ex_q.alu_src;
   assign ex_reg_write = ex_q.reg_write;
   assign ex_mem_read  = ex_q.mem_read;
   assign ex_mem_write = ex_q.mem_write;
   assign ex_branch    = ex_q.branch;
   assign ex_jump      = ex_q.jump;
   assign ex_illegal   = ex_q.illegal;
   assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed bench for id_stage_ctrl: reset, load-use, x0, flush/stall priority,
// memory freeze, decode table and stall-counter saturation.
module tb_id_stage_ctrl;

   // Narrow counter so saturation is reachable in a short run.
   localparam int CNT_W = 8;

   localparam logic [31:0] NOP          = 32'h0000_0013;
   localparam logic [31:0] LW_X5_X1     = {12'd0, 5'd1, 3'd2, 5'd5, 7'b0000011};
   localparam logic [31:0] ADD_X6_X5_X2 = {7'd0, 5'd2, 5'd5, 3'd0, 5'd6, 7'b0110011};
   localparam logic [31:0] LW_X0_X1     = {12'd0, 5'd1, 3'd2, 5'd0, 7'b0000011};
   localparam logic [31:0] ADD_X6_X0_X2 = {7'd0, 5'd2, 5'd0, 3'd0, 5'd6, 7'b0110011};
   localparam logic [31:0] SW_X5_X1     = {7'd0, 5'd5, 5'd1, 3'd2, 5'd0, 7'b0100011};
   localparam logic [31:0] LW_X6_X5     = {12'd0, 5'd5, 3'd2, 5'd6, 7'b0000011};
   localparam logic [31:0] ADD_X7_X6_X0 = {7'd0, 5'd0, 5'd6, 3'd0, 5'd7, 7'b0110011};
   localparam logic [31:0] LW_X5_X5     = {12'd0, 5'd5, 3'd2, 5'd5, 7'b0000011};
   localparam logic [31:0] ADDI_X3      = {12'd1, 5'd0, 3'd0, 5'd3, 7'b0010011};

   // Decode table: opcode, {alu_src,reg_write,mem_read,mem_write,branch,jump,illegal}, imm_sel
   logic [6:0] opc_tab [10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63,
                                7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
   logic [6:0] ctl_tab [10] = '{7'b1110000, 7'b1100000, 7'b1100010, 7'b1001000, 7'b0000100,
                                7'b1100000, 7'b1100000, 7'b0100010, 7'b0100000, 7'b0000001};
   logic       imm_tab [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

   logic             clk = 1'b0;
   logic             rst;
   logic             if_valid;
   logic [31:0]      if_instr;
   logic [31:0]      if_pc;
   logic             ex_flush;
   logic             mem_stall;
   logic             pc_hold;
   logic [31:0]      id_instr;
   logic             imm_sel;
   logic [4:0]       rs1_addr;
   logic [4:0]       rs2_addr;
   logic             ex_valid;
   logic [31:0]      ex_pc;
   logic [4:0]       ex_rd;
   logic             ex_alu_src;
   logic             ex_reg_write;
   logic             ex_mem_read;
   logic             ex_mem_write;
   logic             ex_branch;
   logic             ex_jump;
   logic             ex_illegal;
   logic [CNT_W-1:0] stall_count;

   int tests  = 0;
   int failed = 0;

   id_stage_ctrl #(.NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .ex_flush(ex_flush), .mem_stall(mem_stall), .pc_hold(pc_hold), .id_instr(id_instr),
      .imm_sel(imm_sel), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .ex_valid(ex_valid),
      .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
      .ex_jump(ex_jump), .ex_illegal(ex_illegal), .stall_count(stall_count)
   );

   // Clock / reset
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      rst = 1'b1;
      if_valid = 1'b0; if_instr = NOP; if_pc = 32'd0;
      ex_flush = 1'b0; mem_stall = 1'b0;
      tick;
      tick;
      rst = 1'b0;
   endtask

   // Driver
   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
      if_valid = v;
      if_instr = instr;
      if_pc    = pc;
   endtask

   task automatic test_reset;
      apply_reset;
      drive(1'b1, LW_X5_X1, 32'h100); tick;
      drive(1'b1, ADD_X6_X5_X2, 32'h104); tick;
      tick;
      drive(1'b1, NOP, 32'h108); tick;
      #2 rst = 1'b1;
      #1;
      tests++; if (ex_valid !== 1'b0) begin failed++; $display("FAIL rst_ex_valid: got %b expected 0", ex_valid); end
      tests++; if (ex_reg_write !== 1'b0) begin failed++; $display("FAIL rst_ex_reg_write: got %b expected 0", ex_reg_write); end
      tests++; if (ex_pc !== 32'd0) begin failed++; $display("FAIL rst_ex_pc: got %h expected 0", ex_pc); end
      tests++; if (ex_rd !== 5'd0) begin failed++; $display("FAIL rst_ex_rd: got %0d expected 0", ex_rd); end
      tests++; if (id_instr !== 32'h0000_0013) begin failed++; $display("FAIL rst_id_instr: got %h expected 00000013", id_instr); end
      tests++; if (stall_count !== 8'd0) begin failed++; $display("FAIL rst_stall_count: got %0d expected 0", stall_count); end
      tests++; if (pc_hold !== 1'b0) begin failed++; $display("FAIL rst_pc_hold: got %b expected 0", pc_hold); end
      tests++; if (imm_sel !== 1'b0) begin failed++; $display("FAIL rst_imm_sel: got %b expected 0", imm_sel); end
      tick;
      rst = 1'b0;
   endtask

   task automatic test_load_use;
      apply_reset;
      drive(1'b1, LW_X5_X1, 32'h100); tick;
      drive(1'b1, ADD_X6_X5_X2, 32'h104); tick;
      tests++; if (pc_hold !== 1'b1) begin failed++; $display("FAIL lu_hold: got %b expected 1", pc_hold); end
      tests++; if (ex_mem_read !== 1'b1 || ex_rd !== 5'd5) begin failed++; $display("FAIL lu_load_in_ex: got mr=%b rd=%0d expected mr=1 rd=5", ex_mem_read, ex_rd); end
      tick;
      tests++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0) begin failed++; $display("FAIL lu_bubble: got v=%b mr=%b expected 0 0", ex_valid, ex_mem_read); end
      tests++; if (stall_count !== 8'd1) begin failed++; $display("FAIL lu_count: got %0d expected 1", stall_count); end
      tests++; if (pc_hold !== 1'b0) begin failed++; $display("FAIL lu_release: got %b expected 0", pc_hold); end
      tests++; if (id_instr !== ADD_X6_X5_X2) begin failed++; $display("FAIL lu_id_held: got %h expected %h", id_instr, ADD_X6_X5_X2); end
      drive(1'b1, NOP, 32'h108); tick;
      tests++; if (ex_valid !== 1'b1 || ex_pc !== 32'h104 || ex_rd !== 5'd6 || ex_reg_write !== 1'b1) begin
         failed++; $display("FAIL lu_add_issue: got v=%b pc=%h rd=%0d rw=%b expected 1 104 6 1", ex_valid, ex_pc, ex_rd, ex_reg_write);
      end
      drive(1'b0, NOP, 32'h0); tick; tick;
   endtask

   task automatic test_x0;
      apply_reset;
      drive(1'b1, LW_X0_X1, 32'h100); tick;
      drive(1'b1, ADD_X6_X0_X2, 32'h104); tick;
      tests++; if (pc_hold !== 1'b0) begin failed++; $display("FAIL x0_no_hold: got %b expected 0", pc_hold); end
      drive(1'b1, LW_X5_X1, 32'h108); tick;
      tests++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || stall_count !== 8'd0) begin
         failed++; $display("FAIL x0_add_issue: got v=%b rd=%0d cnt=%0d expected 1 6 0", ex_valid, ex_rd, stall_count);
      end
      drive(1'b1, SW_X5_X1, 32'h10c); tick;
      tests++; if (pc_hold !== 1'b1) begin failed++; $display("FAIL sw_rs2_hold: got %b expected 1", pc_hold); end
      tick;
      tests++; if (stall_count !== 8'd1 || ex_valid !== 1'b0) begin failed++; $display("FAIL sw_rs2_stall: got cnt=%0d v=%b expected 1 0", stall_count, ex_valid); end
      drive(1'b0, NOP, 32'h0); tick;
      tests++; if (ex_mem_write !== 1'b1 || ex_rd !== 5'd0 || ex_reg_write !== 1'b0 || ex_pc !== 32'h10c) begin
         failed++; $display("FAIL sw_issue: got mw=%b rd=%0d rw=%b pc=%h expected 1 0 0 10c", ex_mem_write, ex_rd, ex_reg_write, ex_pc);
      end
      tick;
   endtask

   task automatic test_back_to_back;
      apply_reset;
      drive(1'b1, LW_X5_X1, 32'h200); tick;
      drive(1'b1, LW_X6_X5, 32'h204); tick;
      tests++; if (pc_hold !== 1'b1) begin failed++; $display("FAIL b2b_hold1: got %b expected 1", pc_hold); end
      tick;
      tests++; if (stall_count !== 8'd1 || ex_valid !== 1'b0) begin failed++; $display("FAIL b2b_stall1: got cnt=%0d v=%b expected 1 0", stall_count, ex_valid); end
      drive(1'b1, ADD_X7_X6_X0, 32'h208); tick;
      tests++; if (pc_hold !== 1'b1 || ex_pc !== 32'h204 || ex_rd !== 5'd6) begin
         failed++; $display("FAIL b2b_hold2: got hold=%b pc=%h rd=%0d expected 1 204 6", pc_hold, ex_pc, ex_rd);
      end
      tick;
      tests++; if (stall_count !== 8'd2 || ex_valid !== 1'b0) begin failed++; $display("FAIL b2b_stall2: got cnt=%0d v=%b expected 2 0", stall_count, ex_valid); end
      drive(1'b1, NOP, 32'h20c); tick;
      tests++; if (ex_rd !== 5'd7 || ex_pc !== 32'h208 || pc_hold !== 1'b0 || stall_count !== 8'd2) begin
         failed++; $display("FAIL b2b_add: got rd=%0d pc=%h hold=%b cnt=%0d expected 7 208 0 2", ex_rd, ex_pc, pc_hold, stall_count);
      end
      drive(1'b0, NOP, 32'h0); tick; tick;
   endtask

   task automatic test_flush_vs_stall;
      apply_reset;
      drive(1'b1, LW_X5_X1, 32'h100); tick;
      drive(1'b1, ADD_X6_X5_X2, 32'h104); tick;
      ex_flush = 1'b1;
      #1;
      tests++; if (pc_hold !== 1'b0) begin failed++; $display("FAIL flush_hold: got %b expected 0", pc_hold); end
      tick;
      ex_flush = 1'b0;
      drive(1'b0, NOP, 32'h0);
      tests++; if (id_instr !== NOP || imm_sel !== 1'b0) begin failed++; $display("FAIL flush_ifid: got %h imm=%b expected %h 0", id_instr, imm_sel, NOP); end
      tests++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0) begin failed++; $display("FAIL flush_ex: got v=%b mr=%b expected 0 0", ex_valid, ex_mem_read); end
      tests++; if (stall_count !== 8'd0) begin failed++; $display("FAIL flush_count: got %0d expected 0", stall_count); end
      tick;
      tests++; if (ex_valid !== 1'b0) begin failed++; $display("FAIL flush_no_issue: got %b expected 0", ex_valid); end
   endtask

   task automatic test_mem_freeze;
      apply_reset;
      drive(1'b1, ADDI_X3, 32'h300); tick;
      drive(1'b1, ADD_X6_X5_X2, 32'h304); tick;
      mem_stall = 1'b1; ex_flush = 1'b1;
      drive(1'b1, LW_X5_X1, 32'h308);
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++; if (pc_hold !== 1'b1) begin failed++; $display("FAIL freeze_hold[%0d]: got %b expected 1", i, pc_hold); end
         tick;
         tests++; if (id_instr !== ADD_X6_X5_X2 || ex_valid !== 1'b1 || ex_pc !== 32'h300 || ex_rd !== 5'd3) begin
            failed++; $display("FAIL freeze_regs[%0d]: got id=%h v=%b pc=%h rd=%0d expected %h 1 300 3", i, id_instr, ex_valid, ex_pc, ex_rd, ADD_X6_X5_X2);
         end
      end
      mem_stall = 1'b0;
      #1;
      tests++; if (pc_hold !== 1'b0) begin failed++; $display("FAIL freeze_release: got %b expected 0", pc_hold); end
      tick;
      ex_flush = 1'b0;
      drive(1'b0, NOP, 32'h0);
      tests++; if (id_instr !== NOP || ex_valid !== 1'b0 || ex_pc !== 32'd0) begin
         failed++; $display("FAIL freeze_flush: got id=%h v=%b pc=%h expected %h 0 0", id_instr, ex_valid, ex_pc, NOP);
      end
      // Memory freeze during a load-use stall holds the counter too.
      apply_reset;
      drive(1'b1, LW_X5_X1, 32'h100); tick;
      drive(1'b1, ADD_X6_X5_X2, 32'h104); tick;
      mem_stall = 1'b1;
      tick; tick;
      tests++; if (stall_count !== 8'd0 || ex_mem_read !== 1'b1) begin failed++; $display("FAIL freeze_lu: got cnt=%0d mr=%b expected 0 1", stall_count, ex_mem_read); end
      mem_stall = 1'b0;
      tick;
      tests++; if (stall_count !== 8'd1 || ex_valid !== 1'b0) begin failed++; $display("FAIL freeze_lu_after: got cnt=%0d v=%b expected 1 0", stall_count, ex_valid); end
      drive(1'b0, NOP, 32'h0); tick; tick;
   endtask

   task automatic test_decode;
      logic [6:0] got_ctl;
      logic [4:0] exp_rd;
      apply_reset;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, {20'd0, 5'd9, opc_tab[i]}, 32'h400 + 32'(i * 4));
         tick;
         tests++; if (imm_sel !== imm_tab[i]) begin failed++; $display("FAIL dec_imm[%h]: got %b expected %b", opc_tab[i], imm_sel, imm_tab[i]); end
         drive(1'b0, NOP, 32'h0);
         tick;
         got_ctl = {ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal};
         exp_rd  = ctl_tab[i][5] ? 5'd9 : 5'd0;
         tests++; if (got_ctl !== ctl_tab[i] || ex_valid !== 1'b1) begin
            failed++; $display("FAIL dec_ctl[%h]: got %b v=%b expected %b v=1", opc_tab[i], got_ctl, ex_valid, ctl_tab[i]);
         end
         tests++; if (ex_rd !== exp_rd) begin failed++; $display("FAIL dec_rd[%h]: got %0d expected %0d", opc_tab[i], ex_rd, exp_rd); end
      end
   endtask

   task automatic test_saturation;
      apply_reset;
      drive(1'b1, LW_X5_X5, 32'h500);
      repeat (509) tick;
      tests++; if (stall_count !== 8'd254) begin failed++; $display("FAIL sat_before: got %0d expected 254", stall_count); end
      repeat (100) tick;
      tests++; if (stall_count !== 8'hFF) begin failed++; $display("FAIL sat_hold: got %h expected ff", stall_count); end
      drive(1'b0, NOP, 32'h0); tick; tick;
   endtask

   initial begin
      rst = 1'b1;
      if_valid = 1'b0; if_instr = NOP; if_pc = 32'd0;
      ex_flush = 1'b0; mem_stall = 1'b0;
      test_reset;
      test_load_use;
      test_x0;
      test_back_to_back;
      test_flush_vs_stall;
      test_mem_freeze;
      test_decode;
      test_saturation;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/id_stage_ctrl.md
Name: id_stage_ctrl

Overview:
- Decode-stage controller for the 5-stage RV32I core.
- Owns the IF/ID and ID/EX pipeline registers.
- Drives the immediate generator's select and instruction inputs, and decodes opcodes into EX control bits.
- Sequences load-use stalls, branch/jump flushes and memory-wait freezes, and counts stall cycles for performance monitoring.

Parameters:
NOP_INSTR, 32'h0000_0013, instruction word loaded into IF/ID on reset/flush (ADDI x0,x0,0)
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  asynchronous active-high reset
if_valid  in  1  fetch stage presents a valid instruction
if_instr  in  32  fetched instruction word
if_pc  in  32  PC of fetched instruction
ex_flush  in  1  EX resolved taken branch/jump; kill younger instructions
mem_stall  in  1  data memory busy; freeze whole front end
pc_hold  out  1  fetch must hold PC and if_* this cycle (combinational)
id_instr  out  32  IF/ID instruction, to immediate generator imm_in
imm_sel  out  1  immediate generator select (combinational from IF/ID)
rs1_addr  out  5  id_instr[19:15] to register file
rs2_addr  out  5  id_instr[24:20] to register file
ex_valid  out  1  ID/EX holds a real instruction
ex_pc  out  32  ID/EX PC
ex_rd  out  5  destination register, 0 when no write
ex_alu_src  out  1  ALU operand B = immediate
ex_reg_write  out  1  writeback enable
ex_mem_read  out  1  load
ex_mem_write  out  1  store
ex_branch  out  1  conditional branch
ex_jump  out  1  JAL/JALR
ex_illegal  out  1  undecodable opcode reached EX
stall_count  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (async, any time incl. mid-stall):
  - IF/ID: id_valid=0, id_instr=NOP_INSTR, id_pc=0.
  - All ex_* outputs = 0.
  - stall_count = 0.
- Decode (from id_instr[6:0]; all listed bits =1, others 0):
  - LOAD 0000011: alu_src, reg_write, mem_read, imm_sel.
  - OP-IMM 0010011: alu_src, reg_write, imm_sel.
  - JALR 1100111: alu_src, reg_write, jump, imm_sel.
  - STORE 0100011: alu_src, mem_write, imm_sel.
  - BRANCH 1100011: branch, imm_sel.
  - LUI 0110111 / AUIPC 0010111: alu_src, reg_write, imm_sel.
  - JAL 1101111: reg_write, jump, imm_sel.
  - OP 0110011: reg_write.
  - Other opcode: illegal=1, all other controls 0.
  - imm_sel=0 whenever id_valid=0.
- Register usage and rd:
  - rs1 used by all except LUI/AUIPC/JAL.
  - rs2 used by OP/STORE/BRANCH.
  - ex_rd = instr[11:7] when reg_write, else 0.
- load_use (combinational) = id_valid & ex_valid & ex_mem_read & ex_rd≠0 & ((rs1 used & ex_rd==rs1_addr) | (rs2 used & ex_rd==rs2_addr)).
- Per-edge priority, highest first:
  1. mem_stall=1: IF/ID, ID/EX and stall_count hold; pc_hold=1; ex_flush ignored (upstream keeps it asserted).
  2. ex_flush=1: IF/ID <- {0, NOP_INSTR}; ID/EX <- bubble (all ex_* = 0); pc_hold=0; a concurrent load_use is discarded.
  3. load_use=1: IF/ID holds; ID/EX <- bubble; pc_hold=1; stall_count += 1, saturating at all-ones.
  4. Normal: IF/ID <- {if_valid, if_instr, if_pc}; ID/EX <- decoded IF/ID with ex_valid=id_valid; controls forced 0 when id_valid=0.
- Load-use stall lasts exactly 1 cycle: the bubble clears ex_mem_read.
- Back-to-back loads with a dependency each incur exactly one stall.
- pc_hold = mem_stall | (~ex_flush & load_use).
- Latency: instruction reaches ID/EX one cycle after entering IF/ID when unstalled.
- x0 never triggers a stall.

Test Plan:
- Reset → idle: assert rst mid-stream → all ex_*=0, id_instr=0x00000013, stall_count=0, pc_hold=0.
- Load-use: LW x5,0(x1) then ADD x6,x5,x2 → one cycle pc_hold=1, bubble in EX (ex_valid=0), ADD issues next cycle, stall_count=1.
- Load to x0: LW x0 then ADD x6,x0,x2 → no stall; LW then SW x5 as rs2 → one stall.
- Flush vs stall: ex_flush=1 same cycle as load_use → no stall, IF/ID=NOP invalid, ex_valid=0 next cycle, stall_count unchanged.
- Mem freeze: mem_stall=1 for 3 cycles with ex_flush=1 → all registers unchanged; flush applies on first cycle mem_stall=0.
- Decode sweep: each opcode above plus 0x7F → control bits exactly per table; 0x7F gives ex_illegal=1, ex_reg_write=0; stall_count saturates at 0xFFFF after 65 536+ forced stalls.
